serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 101 ++++++++++
 tb/tb_serial_subtractor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for the bit-serial subtractor.
// The master side issues operands; the slave side returns status and the result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor step per cycle, LSB first.
// Result registers update only on the final RUN edge, so partial results never leak out.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_subtractor_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [WIDTH-1:0] diff_q;
    logic             br;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt;
    logic             d_bit;
    logic             bo_bit;

    // Returns {borrow_out, difference} for one bit position.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        logic dd;
        logic bo;
        dd = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
        return {bo, dd};
    endfunction

    assign {bo_bit, d_bit} = full_sub(a_sh[0], b_sh[0], br);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            d_sh     <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh <= bus.a;
                        b_sh <= bus.b;
                        br   <= bus.bin;
                        d_sh <= '0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    d_sh <= {d_bit, d_sh[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= bo_bit;
                    cnt  <= cnt + CNT_W'(1);
                    // Final step: publish the fully assembled difference and borrow-out.
                    if (cnt == LAST) begin
                        diff_q   <= {d_bit, d_sh[WIDTH-1:1]};
                        borrow_q <= bo_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor (WIDTH=8) against an arithmetic model.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide subtraction; bit W of the result is the borrow-out.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        return {1'b0, x} - {1'b0, y} - (W+1)'(bi);
    endfunction

    // Called just after an edge with the FSM idle; returns just after the edge that leaves DONE.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
        logic [W:0]   exp;
        logic [W-1:0] d0;
        logic         b0;
        logic         hold_ok;
        int           cyc;
        int           busy_cnt;
        exp     = model(ta, tb_v, tbin);
        d0      = bus.diff;
        b0      = bus.borrow;
        hold_ok = 1'b1;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        bus.bin   = tbin;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom);
        cyc      = 0;
        busy_cnt = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) busy_cnt++;
            if (bus.diff !== d0 || bus.borrow !== b0) hold_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, W);
        chk({tag, "_busy_len"}, busy_cnt, W);
        chk({tag, "_hold"}, hold_ok, 1);
        chk({tag, "_diff"}, bus.diff, exp[W-1:0]);
        chk({tag, "_borrow"}, bus.borrow, exp[W]);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, bus.done, 0);
    endtask

    logic [W-1:0] ah [0:40];
    logic [W-1:0] bh [0:40];
    logic         binh [0:40];
    int           rises[$];
    int           done_cnt;
    logic         prev_busy;
    logic [W:0]   exp_h;

    initial begin
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h01;
        bus.bin   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_borrow", bus.borrow, 0);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", bus.busy, 0);

        run_op("d1", 8'h05, 8'h03, 1'b0);
        run_op("d2", 8'h00, 8'h01, 1'b0);
        run_op("d3", 8'h80, 8'h7F, 1'b1);
        run_op("d4", 8'h00, 8'hFF, 1'b1);

        // start held high, operands scrambled every cycle
        done_cnt  = 0;
        prev_busy = bus.busy;
        bus.start = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            if (e == 1) begin
                bus.a = 8'h3C; bus.b = 8'hC3; bus.bin = 1'b1;
            end else begin
                bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
            end
            ah[e] = bus.a; bh[e] = bus.b; binh[e] = bus.bin;
            @(posedge clk); #1;
            if (bus.busy && !prev_busy) rises.push_back(e);
            if (bus.done) begin
                done_cnt++;
                if (e > W) begin
                    exp_h = model(ah[e-W], bh[e-W], binh[e-W]);
                    chk("held_diff", bus.diff, exp_h[W-1:0]);
                    chk("held_borrow", bus.borrow, exp_h[W]);
                end else begin
                    chk("held_early_done", e, W + 1);
                end
            end
            prev_busy = bus.busy;
        end
        bus.start = 1'b0;
        chk("held_accepts", rises.size(), 3);
        chk("held_dones", done_cnt, 3);
        if (rises.size() >= 2) begin
            chk("held_first_accept", rises[0], 1);
            chk("held_interval", rises[1] - rises[0], W + 2);
        end
        @(posedge clk); #1;

        // reset in RUN cycle 4 aborts the operation
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.bin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("abort_was_busy", bus.busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_diff", bus.diff, 0);
        chk("abort_borrow", bus.borrow, 0);
        done_cnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) done_cnt++;
        end
        chk("abort_no_activity", done_cnt, 0);
        run_op("after_rst", 8'h10, 8'h01, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
